// File: rtl/flash_cache.sv
// Direct-mapped, read-only word cache in front of flash_reader.
// Misses fetch one 32-bit word; invalidate requests are deferred until the FSM is idle.
module flash_cache #(
  parameter int LINES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_valid,
  input  logic [23:0] cpu_address,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  input  logic        invalidate,
  output logic        flash_valid,
  output logic [23:0] flash_address,
  output logic        flash_size,
  input  logic [31:0] flash_data,
  input  logic        flash_ready
);

  localparam int IDX_BITS = $clog2(LINES);
  localparam int TAG_BITS = 22 - IDX_BITS;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    FILL,
    RESPOND
  } state_t;

  state_t               state_q, state_d;
  logic [21:0]          addr_q, addr_d;
  logic [LINES-1:0]     valid_q, valid_d;
  logic                 inv_pend_q, inv_pend_d;
  logic                 flash_valid_q, flash_valid_d;
  logic [23:0]          flash_address_q, flash_address_d;
  logic [31:0]          cpu_rdata_q, cpu_rdata_d;

  logic [31:0]          data_mem [LINES];
  logic [TAG_BITS-1:0]  tag_mem  [LINES];
  logic [31:0]          data_rd_q;
  logic [TAG_BITS-1:0]  tag_rd_q;

  logic                 rd_en;
  logic                 wr_en;
  logic [IDX_BITS-1:0]  rd_idx;
  logic [IDX_BITS-1:0]  req_idx;
  logic [TAG_BITS-1:0]  req_tag;
  logic                 hit;
  logic                 unused_addr_bits;

  assign rd_idx           = cpu_address[IDX_BITS+1:2];
  assign req_idx          = addr_q[IDX_BITS-1:0];
  assign req_tag          = addr_q[21:IDX_BITS];
  assign hit              = valid_q[req_idx] && (tag_rd_q == req_tag);
  assign unused_addr_bits = ^cpu_address[1:0];

  // Storage arrays carry no reset so they can map onto block RAM with a registered read.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      data_rd_q <= data_mem[rd_idx];
      tag_rd_q  <= tag_mem[rd_idx];
    end
    if (wr_en) begin
      data_mem[req_idx] <= flash_data;
      tag_mem[req_idx]  <= req_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      valid_q         <= '0;
      inv_pend_q      <= 1'b0;
      flash_valid_q   <= 1'b0;
      flash_address_q <= '0;
      cpu_rdata_q     <= '0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      valid_q         <= valid_d;
      inv_pend_q      <= inv_pend_d;
      flash_valid_q   <= flash_valid_d;
      flash_address_q <= flash_address_d;
      cpu_rdata_q     <= cpu_rdata_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    valid_d         = valid_q;
    inv_pend_d      = inv_pend_q | invalidate;
    flash_valid_d   = flash_valid_q;
    flash_address_d = flash_address_q;
    cpu_rdata_d     = cpu_rdata_q;
    rd_en           = 1'b0;
    wr_en           = 1'b0;

    case (state_q)
      IDLE: begin
        // A pending invalidate takes priority so the line just filled is dropped before any new lookup.
        if (inv_pend_q) begin
          valid_d    = '0;
          inv_pend_d = 1'b0;
        end else if (cpu_valid) begin
          addr_d  = cpu_address[23:2];
          rd_en   = 1'b1;
          state_d = LOOKUP;
        end else if (invalidate) begin
          valid_d    = '0;
          inv_pend_d = 1'b0;
        end
      end

      LOOKUP: begin
        if (hit) begin
          cpu_rdata_d = data_rd_q;
          state_d     = RESPOND;
        end else begin
          flash_valid_d   = 1'b1;
          flash_address_d = {addr_q, 2'b00};
          state_d         = FILL;
        end
      end

      FILL: begin
        if (flash_ready) begin
          flash_valid_d    = 1'b0;
          cpu_rdata_d      = flash_data;
          wr_en            = 1'b1;
          valid_d[req_idx] = 1'b1;
          state_d          = RESPOND;
        end
      end

      RESPOND: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign cpu_ready     = (state_q == RESPOND);
  assign cpu_rdata     = cpu_rdata_q;
  assign flash_valid   = flash_valid_q;
  assign flash_address = flash_address_q;
  assign flash_size    = 1'b1;

endmodule

// File: tb/tb_flash_cache.sv
// Self-checking bench for flash_cache: directed vector table, invalidate/reset corner cases,
// and randomized reads against a word-level cache and flash reference model.
module tb_flash_cache;

  localparam int LINES = 16;

  logic        clk;
  logic        reset;
  logic        cpu_valid;
  logic [23:0] cpu_address;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        invalidate;
  logic        flash_valid;
  logic [23:0] flash_address;
  logic        flash_size;
  logic [31:0] flash_data;
  logic        flash_ready;

  int total;
  int bad;
  int flash_lat;
  bit just_done;
  bit prev_fready;
  bit prev_cready;

  bit          mvalid [LINES];
  logic [21:0] mword  [LINES];

  typedef struct {
    logic [23:0] addr;
    int          lat;
    logic [31:0] exp_data;
    bit          exp_miss;
    logic [23:0] exp_faddr;
    int          exp_cycles;
  } vec_t;

  vec_t vecs [6];

  flash_cache #(.LINES(LINES)) dut (
    .clk           (clk),
    .reset         (reset),
    .cpu_valid     (cpu_valid),
    .cpu_address   (cpu_address),
    .cpu_rdata     (cpu_rdata),
    .cpu_ready     (cpu_ready),
    .invalidate    (invalidate),
    .flash_valid   (flash_valid),
    .flash_address (flash_address),
    .flash_size    (flash_size),
    .flash_data    (flash_data),
    .flash_ready   (flash_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] flash_word(input logic [23:0] a);
    logic [23:0] w;
    w = {a[23:2], 2'b00};
    case (w)
      24'h000100: return 32'hDEADBEEF;
      24'h000140: return 32'h12345678;
      24'h000200: return 32'hCAFEF00D;
      default:    return ({8'h00, w} * 32'h9E3779B1) ^ 32'h5A5A1234;
    endcase
  endfunction

  // Flash reader model: answers flash_lat cycles after valid rises, restarts if valid stays high.
  initial begin
    int cnt;
    cnt         = 0;
    flash_ready = 1'b0;
    flash_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      flash_ready = 1'b0;
      if (flash_valid) begin
        cnt++;
        if (cnt > flash_lat) begin
          flash_ready = 1'b1;
          flash_data  = flash_word(flash_address);
          cnt         = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    just_done = 1'b0;
    if (prev_fready) checkOutput("fvalid_after_fready", 32'(flash_valid), 32'd0);
    if (prev_cready) checkOutput("cpu_ready_pulse", 32'(cpu_ready), 32'd0);
    prev_fready = flash_ready;
    prev_cready = cpu_ready;
  endtask

  task automatic modelClear();
    for (int i = 0; i < LINES; i++) mvalid[i] = 1'b0;
  endtask

  task automatic modelAccess(input logic [23:0] addr, input bit inv);
    int idx;
    idx         = int'(addr[23:2]) % LINES;
    mvalid[idx] = 1'b1;
    mword[idx]  = addr[23:2];
    if (inv) modelClear();
  endtask

  function automatic bit modelMiss(input logic [23:0] addr);
    int idx;
    idx = int'(addr[23:2]) % LINES;
    return !(mvalid[idx] && mword[idx] == addr[23:2]);
  endfunction

  task automatic applyStimulus(input logic [23:0] addr, input int inv_at,
                               output logic [31:0] rdata, output int cycles,
                               output int rises, output logic [23:0] faddr,
                               output bit timed_out);
    bit prev_fv;
    cpu_address = addr;
    cpu_valid   = 1'b1;
    invalidate  = (inv_at == 0);
    cycles      = 0;
    rises       = 0;
    faddr       = '0;
    rdata       = '0;
    timed_out   = 1'b1;
    prev_fv     = flash_valid;
    for (int c = 0; c < 200; c++) begin
      tick();
      cycles++;
      if (flash_valid && !prev_fv) rises++;
      if (flash_valid) faddr = flash_address;
      prev_fv = flash_valid;
      if (cpu_ready) begin
        rdata     = cpu_rdata;
        timed_out = 1'b0;
        break;
      end
      invalidate = (cycles == inv_at);
    end
    invalidate = 1'b0;
    cpu_valid  = 1'b0;
    just_done  = 1'b1;
  endtask

  initial begin
    logic [31:0] rdata;
    logic [23:0] faddr;
    int          cycles;
    int          rises;
    bit          to;
    bit          seen;
    int          ready_cnt;
    bit          prev_inv;

    total       = 0;
    bad         = 0;
    flash_lat   = 20;
    just_done   = 1'b0;
    prev_fready = 1'b0;
    prev_cready = 1'b0;
    reset       = 1'b1;
    cpu_valid   = 1'b0;
    cpu_address = '0;
    invalidate  = 1'b0;
    for (int i = 0; i < LINES; i++) mword[i] = '0;
    modelClear();

    vecs[0] = '{24'h000102, 20, 32'hDEADBEEF, 1'b1, 24'h000100, 23};
    vecs[1] = '{24'h000100, 20, 32'hDEADBEEF, 1'b0, 24'h000000, 2};
    vecs[2] = '{24'h000140, 3,  32'h12345678, 1'b1, 24'h000140, 6};
    vecs[3] = '{24'h000100, 3,  32'hDEADBEEF, 1'b1, 24'h000100, 6};
    vecs[4] = '{24'h000143, 3,  32'h12345678, 1'b1, 24'h000140, 6};
    vecs[5] = '{24'h000140, 3,  32'h12345678, 1'b0, 24'h000000, 2};

    repeat (3) tick();
    checkOutput("reset_cpu_ready", 32'(cpu_ready), 32'd0);
    checkOutput("reset_cpu_rdata", cpu_rdata, 32'd0);
    checkOutput("reset_flash_valid", 32'(flash_valid), 32'd0);
    checkOutput("reset_flash_address", 32'(flash_address), 32'd0);
    reset = 1'b0;
    tick();

    for (int v = 0; v < 6; v++) begin
      tick();
      flash_lat = vecs[v].lat;
      applyStimulus(vecs[v].addr, -1, rdata, cycles, rises, faddr, to);
      checkOutput($sformatf("vec%0d_timeout", v), 32'(to), 32'd0);
      checkOutput($sformatf("vec%0d_rdata", v), rdata, vecs[v].exp_data);
      checkOutput($sformatf("vec%0d_flash_reads", v), 32'(rises), 32'(vecs[v].exp_miss));
      checkOutput($sformatf("vec%0d_cycles", v), 32'(cycles), 32'(vecs[v].exp_cycles));
      if (vecs[v].exp_miss) begin
        checkOutput($sformatf("vec%0d_faddr", v), 32'(faddr), 32'(vecs[v].exp_faddr));
        checkOutput($sformatf("vec%0d_fsize", v), 32'(flash_size), 32'd1);
      end
      modelAccess(vecs[v].addr, 1'b0);
    end

    // Invalidate pulsed mid-fill: data returned, then both index-0 addresses miss.
    tick();
    flash_lat = 10;
    applyStimulus(24'h000200, 5, rdata, cycles, rises, faddr, to);
    checkOutput("inv_fill_rdata", rdata, 32'hCAFEF00D);
    checkOutput("inv_fill_flash_reads", 32'(rises), 32'd1);
    modelAccess(24'h000200, 1'b1);
    tick();
    flash_lat = 2;
    applyStimulus(24'h000200, -1, rdata, cycles, rises, faddr, to);
    checkOutput("inv_reread200_rdata", rdata, 32'hCAFEF00D);
    checkOutput("inv_reread200_flash_reads", 32'(rises), 32'd1);
    checkOutput("inv_reread200_cycles", 32'(cycles), 32'd6);
    modelAccess(24'h000200, 1'b0);
    tick();
    applyStimulus(24'h000100, -1, rdata, cycles, rises, faddr, to);
    checkOutput("inv_reread100_rdata", rdata, 32'hDEADBEEF);
    checkOutput("inv_reread100_flash_reads", 32'(rises), 32'd1);
    modelAccess(24'h000100, 1'b0);

    // Reset during a fill aborts the read with no response.
    tick();
    flash_lat   = 30;
    cpu_address = 24'h000104;
    cpu_valid   = 1'b1;
    seen        = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      tick();
      seen = flash_valid;
    end
    checkOutput("rst_fill_started", 32'(seen), 32'd1);
    repeat (3) tick();
    reset     = 1'b1;
    cpu_valid = 1'b0;
    tick();
    checkOutput("rst_flash_valid_dropped", 32'(flash_valid), 32'd0);
    reset     = 1'b0;
    ready_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (cpu_ready) ready_cnt++;
    end
    checkOutput("rst_no_cpu_ready", 32'(ready_cnt), 32'd0);
    modelClear();
    flash_lat = 1;
    applyStimulus(24'h000100, -1, rdata, cycles, rises, faddr, to);
    checkOutput("rst_reread_rdata", rdata, 32'hDEADBEEF);
    checkOutput("rst_reread_flash_reads", 32'(rises), 32'd1);
    modelAccess(24'h000100, 1'b0);

    // Back-to-back random reads against the reference model.
    prev_inv = 1'b0;
    for (int i = 0; i < 100; i++) begin
      logic [21:0] word;
      logic [23:0] addr;
      int          lat;
      bit          do_inv;
      bit          exp_miss;
      int          exp_cycles;
      if ($urandom_range(0, 7) == 0) word = 22'($urandom_range(0, 32'h3FFFFF));
      else word = 22'($urandom_range(0, 63));
      addr     = {word, 2'($urandom_range(0, 3))};
      lat      = int'($urandom_range(0, 4));
      do_inv   = !prev_inv && ($urandom_range(0, 9) == 0);
      exp_miss = modelMiss(addr);
      exp_cycles = (exp_miss ? 3 + lat : 2) + int'(just_done) + int'(prev_inv);
      flash_lat  = lat;
      applyStimulus(addr, do_inv ? 1 : -1, rdata, cycles, rises, faddr, to);
      checkOutput($sformatf("rnd%0d_rdata", i), rdata, flash_word(addr));
      checkOutput($sformatf("rnd%0d_flash_reads", i), 32'(rises), 32'(exp_miss));
      checkOutput($sformatf("rnd%0d_cycles", i), 32'(cycles), 32'(exp_cycles));
      if (exp_miss) checkOutput($sformatf("rnd%0d_faddr", i), 32'(faddr), 32'({word, 2'b00}));
      modelAccess(addr, do_inv);
      prev_inv = do_inv;
    end

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
